// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit and the data memory.
// Request side is valid/ready; the response is a single-cycle valid with read data.
// master = LSU side, slave = memory side.
interface mem_lsu_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Purpose: MEM-stage load/store unit running one access over a valid/ready data bus.
// Latency: aligned op stalls >=3 cycles (IDLE,REQ,WAIT), result in DONE; misaligned stalls 1 cycle.
// Backpressure: bus_req_valid held with stable fields until bus_req_ready; WAIT aborts after TIMEOUT.
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_req_wen,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_mem_stall,
  output logic [63:0] o_rdata,
  output logic        o_err,
  mem_lsu_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [2:0]  r_off;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [7:0]  r_cnt;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_misaligned;
  logic [7:0]  w_strb_base;
  logic [7:0]  w_strb;
  logic [63:0] w_wdata;
  logic [63:0] w_shift;
  logic [63:0] w_ext;
  logic        w_latch;
  logic        w_rsp_take;
  logic        w_timeout;
  logic        w_misalign_take;

  // Alignment check on the incoming request: natural alignment per access size.
  always_comb begin
    w_misaligned = 1'b0;
    case (i_req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = i_req_addr[0];
      2'd2:    w_misaligned = |i_req_addr[1:0];
      default: w_misaligned = |i_req_addr[2:0];
    endcase
  end

  // Byte-lane strobe and replicated store data, so any lane position picks up the right bytes.
  always_comb begin
    w_strb_base = 8'h00;
    w_wdata     = '0;
    case (i_req_size)
      2'd0: begin
        w_strb_base = 8'h01;
        w_wdata     = {8{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_strb_base = 8'h03;
        w_wdata     = {4{i_req_wdata[15:0]}};
      end
      2'd2: begin
        w_strb_base = 8'h0F;
        w_wdata     = {2{i_req_wdata[31:0]}};
      end
      default: begin
        w_strb_base = 8'hFF;
        w_wdata     = i_req_wdata;
      end
    endcase
    w_strb = w_strb_base << i_req_addr[2:0];
  end

  // Load extraction: move the addressed lane to bit 0, then truncate and extend by size.
  always_comb begin
    w_shift = bus.bus_rdata >> {r_off, 3'b000};
    w_ext   = '0;
    case (r_size)
      2'd0:    w_ext = r_unsigned ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = r_unsigned ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
      2'd2:    w_ext = r_unsigned ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
      default: w_ext = w_shift;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and per-transition strobes; response outside WAIT is never looked at.
  always_comb begin
    w_next          = r_state;
    w_latch         = 1'b0;
    w_rsp_take      = 1'b0;
    w_timeout       = 1'b0;
    w_misalign_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_misaligned) begin
            w_next          = S_DONE;
            w_misalign_take = 1'b1;
          end else begin
            w_next  = S_REQ;
            w_latch = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_req_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.bus_rsp_valid) begin
          w_next     = S_DONE;
          w_rsp_take = 1'b1;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch, WAIT cycle counter, and result/error registers presented in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_off      <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= 8'h00;
      r_cnt      <= 8'd0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_we       <= i_req_wen;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_off      <= i_req_addr[2:0];
        r_addr     <= {i_req_addr[63:3], 3'b000};
        r_wdata    <= w_wdata;
        r_wstrb    <= i_req_wen ? w_strb : 8'h00;
      end
      // Counter only runs while we sit in WAIT; any exit clears it for the next access.
      if (r_state == S_WAIT && w_next == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
      // Error is set only on the transition into DONE, so it lasts exactly the DONE cycle.
      r_err <= w_misalign_take | w_timeout;
      if (w_rsp_take) begin
        r_rdata <= r_we ? '0 : w_ext;
      end else if (w_misalign_take || w_timeout) begin
        r_rdata <= '0;
      end
    end
  end

  // Pipeline stall and result outputs; rdata is gated so stale results never leak outside DONE.
  always_comb begin
    o_mem_stall = i_req_valid & (r_state != S_DONE);
    o_rdata     = (r_state == S_DONE) ? r_rdata : '0;
    o_err       = r_err;
  end

  // Bus request drive from the latched fields so they stay stable while waiting for ready.
  always_comb begin
    bus.bus_req_valid = (r_state == S_REQ);
    bus.bus_we        = r_we;
    bus.bus_addr      = r_addr;
    bus.bus_wdata     = r_wdata;
    bus.bus_wstrb     = r_wstrb;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: the bench plays the data memory with programmable
// ready/response delays and checks results against hand-computed values.
module tb_mem_lsu;
  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        i_req_wen;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_mem_stall;
  logic [63:0] o_rdata;
  logic        o_err;

  int n_tests;
  int n_fail;

  mem_lsu_if b ();

  mem_lsu #(.TIMEOUT(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_wen      (i_req_wen),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_mem_stall    (o_mem_stall),
    .o_rdata        (o_rdata),
    .o_err          (o_err),
    .bus            (b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one op from IDLE to the DONE cycle, acting as memory. rsp_dly < 0 means never respond.
  task automatic run_op(
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  int          rdy_dly,
    input  int          rsp_dly,
    input  logic [63:0] rsp_data,
    output int          stalls,
    output int          reqv,
    output int          errs,
    output logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] bwdata,
    output logic [63:0] baddr,
    output logic        stable,
    output logic        done
  );
    int  rdy_cnt;
    int  rsp_cnt;
    bit  in_wait;
    bit  rsp_now;
    i_req_valid    = 1'b1;
    i_req_wen      = wen;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    stalls = 0; reqv = 0; errs = 0; rdata = '0; wstrb = '0; bwdata = '0; baddr = '0;
    stable = 1'b1; done = 1'b0;
    rdy_cnt = 0; rsp_cnt = 0; in_wait = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      b.bus_req_ready = b.bus_req_valid && (rdy_cnt >= rdy_dly);
      rsp_now         = in_wait && (rsp_dly >= 0) && (rsp_cnt >= rsp_dly);
      b.bus_rsp_valid = rsp_now;
      b.bus_rdata     = rsp_data;
      #1;
      if (o_mem_stall) stalls++;
      if (o_err) errs++;
      if (b.bus_req_valid) begin
        if (reqv > 0 && (b.bus_wstrb !== wstrb || b.bus_wdata !== bwdata || b.bus_addr !== baddr))
          stable = 1'b0;
        wstrb  = b.bus_wstrb;
        bwdata = b.bus_wdata;
        baddr  = b.bus_addr;
        reqv++;
      end
      if (!o_mem_stall) begin
        done  = 1'b1;
        rdata = o_rdata;
      end
      if (b.bus_req_valid && !b.bus_req_ready) rdy_cnt++;
      if (in_wait && !rsp_now) rsp_cnt++;
      if (rsp_now) in_wait = 1'b0;
      if (b.bus_req_valid && b.bus_req_ready) in_wait = 1'b1;
      @(negedge clk);
    end
    i_req_valid     = 1'b0;
    b.bus_req_ready = 1'b0;
    b.bus_rsp_valid = 1'b0;
    b.bus_rdata     = '0;
  endtask

  int          st, rq, er;
  logic [63:0] rd, wd, ba;
  logic [7:0]  ws;
  logic        stb, dn;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = '0; i_req_wdata = '0;
    b.bus_req_ready = 1'b0; b.bus_rsp_valid = 1'b0; b.bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {63'd0, o_mem_stall}, 64'd0);
    chk("rst_reqv",  {63'd0, b.bus_req_valid}, 64'd0);
    chk("rst_err",   {63'd0, o_err}, 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_wstrb", {56'd0, b.bus_wstrb}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // lb, sign-extended byte from lane 3
    run_op(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 0, 0, 64'h0000_0000_F000_0000,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("lb_done",   {63'd0, dn}, 64'd1);
    chk("lb_rdata",  rd, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("lb_stall",  64'(st), 64'd3);
    chk("lb_reqv",   64'(rq), 64'd1);
    chk("lb_err",    64'(er), 64'd0);
    chk("lb_wstrb",  {56'd0, ws}, 64'd0);
    chk("lb_addr",   ba, 64'h8000_0000);

    // lhu from lane 6
    run_op(1'b0, 2'd1, 1'b1, 64'h0000_1006, 64'd0, 0, 0, 64'hBEEF_0000_0000_0000,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("lhu_rdata", rd, 64'h0000_0000_0000_BEEF);
    chk("lhu_stall", 64'(st), 64'd3);

    // lh sign-extended from lane 2, response delayed 2 cycles
    run_op(1'b0, 2'd1, 1'b0, 64'h0000_2002, 64'd0, 0, 2, 64'h0000_0000_8001_0000,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("lh_rdata",  rd, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_stall",  64'(st), 64'd5);

    // lwu and lw from upper word
    run_op(1'b0, 2'd2, 1'b1, 64'h0000_3004, 64'd0, 0, 0, 64'h89AB_CDEF_0000_0000,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("lwu_rdata", rd, 64'h0000_0000_89AB_CDEF);
    run_op(1'b0, 2'd2, 1'b0, 64'h0000_3004, 64'd0, 0, 0, 64'h89AB_CDEF_0000_0000,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("lw_rdata",  rd, 64'hFFFF_FFFF_89AB_CDEF);

    // ld aligned
    run_op(1'b0, 2'd3, 1'b0, 64'h0000_4018, 64'd0, 0, 0, 64'hDEAD_BEEF_0123_4567,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("ld_rdata",  rd, 64'hDEAD_BEEF_0123_4567);
    chk("ld_addr",   ba, 64'h0000_4018);

    // sw to upper word with ready delayed 4 cycles
    run_op(1'b1, 2'd2, 1'b0, 64'h0000_1004, 64'h0000_0000_1234_5678, 4, 0, 64'hFFFF_FFFF_FFFF_FFFF,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("sw_wstrb",  {56'd0, ws}, 64'h0000_0000_0000_00F0);
    chk("sw_wdata",  wd, 64'h1234_5678_1234_5678);
    chk("sw_reqv",   64'(rq), 64'd5);
    chk("sw_stable", {63'd0, stb}, 64'd1);
    chk("sw_stall",  64'(st), 64'd7);
    chk("sw_rdata",  rd, 64'd0);
    chk("sw_err",    64'(er), 64'd0);

    // sb lane 5, sd aligned
    run_op(1'b1, 2'd0, 1'b0, 64'h0000_0005, 64'h0000_0000_0000_00AB, 0, 0, 64'd0,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("sb_wstrb",  {56'd0, ws}, 64'h0000_0000_0000_0020);
    chk("sb_wdata",  wd, 64'hABAB_ABAB_ABAB_ABAB);
    run_op(1'b1, 2'd3, 1'b0, 64'h0000_0010, 64'h0123_4567_89AB_CDEF, 1, 1, 64'd0,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("sd_wstrb",  {56'd0, ws}, 64'h0000_0000_0000_00FF);
    chk("sd_wdata",  wd, 64'h0123_4567_89AB_CDEF);
    chk("sd_addr",   ba, 64'h0000_0010);

    // misaligned lw: no bus request, one stall cycle, one-cycle err
    run_op(1'b0, 2'd2, 1'b0, 64'h0000_1002, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("mis_reqv",  64'(rq), 64'd0);
    chk("mis_err",   64'(er), 64'd1);
    chk("mis_stall", 64'(st), 64'd1);
    chk("mis_rdata", rd, 64'd0);
    #1;
    chk("mis_err_gone", {63'd0, o_err}, 64'd0);

    // ld with no response: abort after the timeout window
    run_op(1'b0, 2'd3, 1'b0, 64'h0000_5000, 64'd0, 0, -1, 64'hFFFF_FFFF_FFFF_FFFF,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("to_done",   {63'd0, dn}, 64'd1);
    chk("to_err",    64'(er), 64'd1);
    chk("to_rdata",  rd, 64'd0);
    chk("to_window", {63'd0, (st >= 250 && st <= 260)}, 64'd1);
    #1;
    chk("to_idle_stall", {63'd0, o_mem_stall}, 64'd0);
    chk("to_idle_err",   {63'd0, o_err}, 64'd0);

    // reset in WAIT followed by a stale response
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_addr = 64'h0000_6000; b.bus_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wait_reqv",  {63'd0, b.bus_req_valid}, 64'd0);
    chk("wait_stall", {63'd0, o_mem_stall}, 64'd1);
    @(negedge clk);
    rst = 1'b1; i_req_valid = 1'b0; b.bus_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; b.bus_rsp_valid = 1'b1; b.bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("rstw_err",   {63'd0, o_err}, 64'd0);
    chk("rstw_rdata", o_rdata, 64'd0);
    @(negedge clk);
    b.bus_rsp_valid = 1'b0;
    #1;
    chk("rstw_err2",   {63'd0, o_err}, 64'd0);
    chk("rstw_rdata2", o_rdata, 64'd0);
    chk("rstw_reqv",   {63'd0, b.bus_req_valid}, 64'd0);
    chk("rstw_stall",  {63'd0, o_mem_stall}, 64'd0);

    // unit still usable after the reset
    @(negedge clk);
    run_op(1'b0, 2'd0, 1'b1, 64'h0000_7001, 64'd0, 0, 0, 64'h0000_0000_0000_9A00,
           st, rq, er, rd, ws, wd, ba, stb, dn);
    chk("post_lbu",  rd, 64'h0000_0000_0000_009A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
